// File: rtl/seq_pkg.sv
// Shared definitions for the serial sequence detector slice: serializer FSM
// states and the default idle line level.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // Level held on the serial line between words; the detector sees it every clock.
  localparam logic IDLE_BIT_DEF = 1'b0;

endpackage

// File: rtl/ser_shift_reg.sv
// Loadable shift register for the bit serializer. On load it keeps the word
// minus the bit that goes out first (that bit is offered combinationally on
// first_bit). sout always presents the bit that goes out after the current one.
module ser_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             first_bit,
  output logic             sout
);

  logic [WIDTH-1:0] q;

  assign first_bit = MSB_FIRST ? d[WIDTH-1] : d[0];
  assign sout      = MSB_FIRST ? q[WIDTH-1] : q[0];

  // Load the remainder of the word, or advance one position toward the output end.
  always_ff @(posedge clk) begin
    if (load) begin
      q <= MSB_FIRST ? {d[WIDTH-2:0], 1'b0} : {1'b0, d[WIDTH-1:1]};
    end else if (shift) begin
      q <= MSB_FIRST ? {q[WIDTH-2:0], 1'b0} : {1'b0, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector. Words arrive over
// valid/ready and leave one bit per clock on ser_bit with no bubble between
// back-to-back words; the idle level is held otherwise.
// Optional feature: define SER_PARITY_EN to append an even-parity bit to every
// word (frame length WIDTH+1 instead of WIDTH).
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state and rst, never on in_valid; once
// in_valid is raised the word is expected to stay stable until it transfers.
module bit_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_done,
  output ser_state_t       dbg_state
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  ser_state_t    state;
  logic [CW-1:0] cnt;
  logic          last_cycle;
  logic          accept;
  logic          do_shift;
  logic          first_bit;
  logic          next_bit;

`ifdef SER_PARITY_EN
  logic par_q;
  // The parity bit closes the frame, so it is the cycle that can take a new word.
  assign last_cycle = (state == PARITY);
`else
  assign last_cycle = (state == SHIFT) && (cnt == LAST_CNT);
`endif

  assign in_ready  = !rst && ((state == IDLE) || last_cycle);
  assign accept    = in_valid && in_ready;
  assign do_shift  = !rst && (state == SHIFT) && (cnt != LAST_CNT);
  assign dbg_state = state;

  ser_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk       (clk),
    .load      (accept),
    .shift     (do_shift),
    .d         (in_data),
    .first_bit (first_bit),
    .sout      (next_bit)
  );

`ifdef SER_PARITY_EN
  // Capture even parity of the accepted word for the trailing frame bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      par_q <= ^in_data;
    end
  end
`endif

  // Frame FSM: the registered outputs always describe the bit currently on the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ser_bit   <= IDLE_BIT;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
    end else if (accept) begin
      // New word starts next cycle, whether from IDLE or chained onto the last bit.
      state     <= SHIFT;
      cnt       <= '0;
      ser_bit   <= first_bit;
      ser_valid <= 1'b1;
      word_done <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          if (cnt != LAST_CNT) begin
            cnt       <= cnt + CW'(1);
            ser_bit   <= next_bit;
            ser_valid <= 1'b1;
`ifdef SER_PARITY_EN
            word_done <= 1'b0;
`else
            word_done <= (cnt == PRE_LAST);
`endif
          end else begin
`ifdef SER_PARITY_EN
            state     <= PARITY;
            ser_bit   <= par_q;
            ser_valid <= 1'b1;
            word_done <= 1'b1;
`else
            state     <= IDLE;
            cnt       <= '0;
            ser_bit   <= IDLE_BIT;
            ser_valid <= 1'b0;
            word_done <= 1'b0;
`endif
          end
        end
`ifdef SER_PARITY_EN
        PARITY: begin
          state     <= IDLE;
          cnt       <= '0;
          ser_bit   <= IDLE_BIT;
          ser_valid <= 1'b0;
          word_done <= 1'b0;
        end
`endif
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          ser_bit   <= IDLE_BIT;
          ser_valid <= 1'b0;
          word_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: one MSB-first and one LSB-first instance, a
// per-instance expected-bit queue filled as words are handed over, and a
// negedge monitor that pops and compares every serial cycle.
module tb_bit_serializer;
  import seq_pkg::*;

  localparam int   W      = 8;
  localparam logic IDLE_L = 1'b0;
`ifdef SER_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0] in_data, in_data_l;
  logic         in_valid, in_valid_l;
  logic         in_ready, ser_bit, ser_valid, word_done;
  logic         in_ready_l, ser_bit_l, ser_valid_l, word_done_l;
  ser_state_t   dbg_state, dbg_state_l;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_L)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .word_done(word_done), .dbg_state(dbg_state)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_L)) dut_l (
    .clk(clk), .rst(rst), .in_data(in_data_l), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .ser_bit(ser_bit_l), .ser_valid(ser_valid_l), .word_done(word_done_l), .dbg_state(dbg_state_l)
  );

  // scoreboard: each entry is {expected ser_bit, expected word_done}
  logic [1:0] exp_q[$];
  logic [1:0] exp_l_q[$];
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: MSB-first instance
  always @(negedge clk) begin
    logic [1:0] e;
    if (mon_en) begin
      if (ser_valid === 1'b1) begin
        if (exp_q.size() == 0) check("m_unexpected_bit", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("m_ser_bit", 32'(ser_bit), 32'(e[1]));
          check("m_word_done", 32'(word_done), 32'(e[0]));
        end
      end else begin
        check("m_idle_bit", 32'(ser_bit), 32'(IDLE_L));
        check("m_idle_done", 32'(word_done), 32'd0);
        check("m_gap", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  // monitor: LSB-first instance
  always @(negedge clk) begin
    logic [1:0] e;
    if (mon_en) begin
      if (ser_valid_l === 1'b1) begin
        if (exp_l_q.size() == 0) check("l_unexpected_bit", 32'd1, 32'd0);
        else begin
          e = exp_l_q.pop_front();
          check("l_ser_bit", 32'(ser_bit_l), 32'(e[1]));
          check("l_word_done", 32'(word_done_l), 32'(e[0]));
        end
      end else begin
        check("l_idle_bit", 32'(ser_bit_l), 32'(IDLE_L));
        check("l_idle_done", 32'(word_done_l), 32'd0);
        check("l_gap", 32'(exp_l_q.size()), 32'd0);
      end
    end
  end

  // in_ready must be high exactly when out of reset and idle or on a frame's last bit
  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      check("m_in_ready", 32'(in_ready), 32'(!rst && (!ser_valid || word_done)));
      check("l_in_ready", 32'(in_ready_l), 32'(!rst && (!ser_valid_l || word_done_l)));
    end
  end

  // driver: present a word, wait (bounded) for in_ready, queue its frame, return
  // just after the negedge following the transfer edge with in_valid still high.
  // e holds the expected line order, first bit in e[W-1].
  task automatic send(input bit lsb, input logic [W-1:0] d, input logic [W-1:0] e,
                      input logic p, output int waits);
    bit got;
    logic [1:0] v;
    got   = 1'b0;
    waits = 0;
    if (lsb) begin in_data_l = d; in_valid_l = 1'b1; end
    else     begin in_data   = d; in_valid   = 1'b1; end
    while (!got && waits < 60) begin
      #1;
      if ((lsb ? in_ready_l : in_ready) === 1'b1) got = 1'b1;
      else begin
        waits++;
        @(negedge clk);
      end
    end
    if (!got) begin
      check("ready_timeout", 32'(waits), 32'd0);
      in_valid = 1'b0; in_valid_l = 1'b0;
    end else begin
      for (int i = W - 1; i >= 0; i--) begin
        v = {e[i], ((i == 0) && (FRAME == W))};
        if (lsb) exp_l_q.push_back(v); else exp_q.push_back(v);
      end
`ifdef SER_PARITY_EN
      v = {p, 1'b1};
      if (lsb) exp_l_q.push_back(v); else exp_q.push_back(v);
`else
      if (p === 1'bx) $display("note: parity expectation unknown");
`endif
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    in_valid   = 1'b0;
    in_valid_l = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_bits;
    logic         exp_par;
    int           gap;
  } vec_t;

  vec_t tbl[12];
  int   w, w2;

  initial begin
    in_valid = 1'b0; in_valid_l = 1'b0; in_data = '0; in_data_l = '0;

    tbl[0]  = '{8'hA5, 8'hA5, 1'b0, 0};
    tbl[1]  = '{8'h05, 8'h05, 1'b0, 0};
    tbl[2]  = '{8'hA0, 8'hA0, 1'b0, 1};
    tbl[3]  = '{8'hFF, 8'hFF, 1'b0, 0};
    tbl[4]  = '{8'h07, 8'h07, 1'b1, 2};
    tbl[5]  = '{8'h00, 8'h00, 1'b0, 0};
    tbl[6]  = '{8'h80, 8'h80, 1'b1, 0};
    tbl[7]  = '{8'h3C, 8'h3C, 1'b0, 1};
    tbl[8]  = '{8'h01, 8'h01, 1'b1, 0};
    tbl[9]  = '{8'h5A, 8'h5A, 1'b0, 3};
    tbl[10] = '{8'hC3, 8'hC3, 1'b0, 0};
    tbl[11] = '{8'h1F, 8'h1F, 1'b1, 0};
    for (int i = 0; i < 12; i++) if (tbl[i].gap != 0) tbl[i].gap = int'($urandom_range(1, 3));

    // reset held with a word offered: nothing transfers
    @(posedge clk);
    @(negedge clk);
    mon_en   = 1'b1;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_ser_valid", 32'(ser_valid), 32'd0);
      check("rst_ser_bit", 32'(ser_bit), 32'(IDLE_L));
      @(negedge clk);
    end
    rst = 1'b0;

    // first transfer right after reset; 8'hA5 MSB first
    send(1'b0, 8'hA5, 8'hA5, 1'b0, w);
    check("accept_after_rst", 32'(w), 32'd0);
    in_valid = 1'b0;
    repeat (FRAME) @(negedge clk);
    #1;
    check("post_frame_valid", 32'(ser_valid), 32'd0);
    check("post_frame_bit", 32'(ser_bit), 32'(IDLE_L));
    idle(2);

    // back-to-back: second word transfers on the first word's last-bit cycle
    send(1'b0, 8'h05, 8'h05, 1'b0, w);
    send(1'b0, 8'hA0, 8'hA0, 1'b0, w2);
    check("b2b_wait", 32'(w2), 32'(FRAME - 1));
    idle(FRAME + 2);

    // table of words with mixed gaps (gap 0 keeps in_valid high -> chained)
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].gap != 0) idle(tbl[i].gap);
      send(1'b0, tbl[i].data, tbl[i].exp_bits, tbl[i].exp_par, w);
    end
    idle(FRAME + 3);

    // reset on the 4th bit of 8'hFF aborts the word
    send(1'b0, 8'hFF, 8'hFF, 1'b0, w);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_ser_valid", 32'(ser_valid), 32'd0);
    check("abort_ser_bit", 32'(ser_bit), 32'(IDLE_L));
    check("abort_word_done", 32'(word_done), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    idle(3);

    // LSB-first instance: 8'h01 -> 1 then zeros; 8'h05 -> 1,0,1,0,0,0,0,0
    send(1'b1, 8'h01, 8'h80, 1'b1, w);
    check("lsb_accept_wait", 32'(w), 32'd0);
    send(1'b1, 8'h05, 8'hA0, 1'b0, w2);
    check("lsb_b2b_wait", 32'(w2), 32'(FRAME - 1));
    idle(FRAME + 3);

    check("drain", 32'(exp_q.size() + exp_l_q.size()), 32'd0);
    mon_en = 1'b0;
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
